// File: rtl/mul_pkg.sv
// Shared types and widths for the multiply sequencer.
package mul_pkg;

    localparam int XLEN = 32;
    localparam int PLEN = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FIX    = 3'd3,
        ST_RESP   = 3'd4,
        ST_DRAIN  = 3'd5
    } mul_seq_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request, multiplier and response channels of the multiply sequencer.
interface mul_sequencer_if;
    import mul_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            flush;
    logic            mul_run;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic            mul_ready;
    logic [PLEN-1:0] mul_prod;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            resp_ready;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush,
        input  mul_ready, mul_prod, resp_ready,
        output req_ready, mul_run, mul_a, mul_b, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush,
        output mul_ready, mul_prod, resp_ready,
        input  req_ready, mul_run, mul_a, mul_b, resp_valid, resp_data
    );

endinterface

// File: rtl/mul_fixup.sv
// Derives the requested result word from a signed 32x32 product; the unsigned
// high-word variants add back the operands whose sign bit was misread as negative.
module mul_fixup
    import mul_pkg::*;
(
    input  mul_op_t         op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [PLEN-1:0] prod,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] corr_rs2_neg;
    logic [XLEN-1:0] corr_rs1_neg;

    assign hi           = prod[PLEN-1:XLEN];
    assign lo           = prod[XLEN-1:0];
    assign corr_rs2_neg = rs2[XLEN-1] ? rs1 : '0;
    assign corr_rs1_neg = rs1[XLEN-1] ? rs2 : '0;

    always_comb begin
        result = lo;
        case (op)
            OP_MUL:    result = lo;
            OP_MULH:   result = hi;
            OP_MULHSU: result = hi + corr_rs2_neg;
            OP_MULHU:  result = hi + corr_rs1_neg + corr_rs2_neg;
            default:   result = lo;
        endcase
    end

endmodule

// File: rtl/mul_sequencer.sv
// Sequences multiply requests onto a shared signed multiplier, reusing the last
// product when the operands repeat.
//
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | one-cycle start pulse to the multiplier
// WAIT   | waiting for the product
// FIX    | forming the result word from the cached product
// RESP   | result presented until consumed
// DRAIN  | flushed; swallowing the pending product
module mul_sequencer
    import mul_pkg::*;
(
    input logic            clk,
    input logic            reset,
    mul_sequencer_if.slave bus
);

    mul_seq_state_t  state;
    mul_seq_state_t  state_nxt;

    mul_op_t         op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] resp_data_q;
    logic [XLEN-1:0] fix_result;

    logic            cache_valid;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic [PLEN-1:0] cache_prod;

    logic            req_ready_c;
    logic            mul_run_c;
    logic            accept;
    logic            hit;
    logic            launch_load;
    logic            capture;
    logic            cache_kill;
    logic            fix_load;

    // Incoming operands are the ones about to be latched, so comparing them
    // here is the same as comparing the latched copy.
    assign accept      = bus.req_valid & req_ready_c;
    assign hit         = cache_valid && (bus.req_rs1 == cache_a) && (bus.req_rs2 == cache_b);
    assign launch_load = accept & ~hit;
    assign capture     = (state == ST_WAIT) & ~bus.flush & bus.mul_ready;
    assign cache_kill  = bus.flush & ((state == ST_LAUNCH) | (state == ST_WAIT));
    assign fix_load    = (state == ST_FIX) & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        mul_run_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_c = ~bus.flush;
                if (accept) begin
                    state_nxt = hit ? ST_FIX : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                mul_run_c = 1'b1;
                state_nxt = bus.flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    state_nxt = ST_DRAIN;
                end else if (bus.mul_ready) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = bus.flush ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (bus.flush || bus.resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.mul_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_MUL;
            rs1_q       <= '0;
            rs2_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            resp_data_q <= '0;
            cache_valid <= 1'b0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_prod  <= '0;
        end else begin
            if (accept) begin
                op_q  <= mul_op_t'(bus.req_op);
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
            end
            // Operands only change on a new launch, so they stay put until capture.
            if (launch_load) begin
                mul_a_q <= bus.req_rs1;
                mul_b_q <= bus.req_rs2;
            end
            if (cache_kill) begin
                cache_valid <= 1'b0;
            end else if (capture) begin
                cache_valid <= 1'b1;
                cache_a     <= rs1_q;
                cache_b     <= rs2_q;
                cache_prod  <= bus.mul_prod;
            end
            if (fix_load) begin
                resp_data_q <= fix_result;
            end
        end
    end

    mul_fixup u_fixup (
        .op     (op_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .prod   (cache_prod),
        .result (fix_result)
    );

    assign bus.req_ready  = req_ready_c;
    assign bus.mul_run    = mul_run_c;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_data  = resp_data_q;

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  upstream execute stage presents a multiply request.
REQ-004 req_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
REQ-005 req_rs1  input  32  operand A.
REQ-006 req_rs2  input  32  operand B.
REQ-007 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-008 flush  input  1  kill any in-flight request; no response issued for it.
REQ-009 mul_run  output  1  one-cycle start pulse to the signed 32x32 multiplier.
REQ-010 mul_a, mul_b  output  32 each  multiplier operands, held stable from LAUNCH until the product is captured.
REQ-011 mul_ready  input  1  multiplier product valid.
REQ-012 mul_prod  input  64  signed product {hi, lo}.
REQ-013 resp_valid  output  1  result available downstream.
REQ-014 resp_data  output  32  result word.
REQ-015 resp_ready  input  1  downstream consumes the result when resp_valid & resp_ready.

Function
REQ-016 States: IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
REQ-017 req_ready = 1 only in IDLE with flush = 0.
REQ-018 IDLE, on accept: latch op/rs1/rs2; go to FIX on a cache hit, else LAUNCH.
REQ-019 Cache hit: cache_valid = 1 and latched rs1/rs2 equal the cached operands, with any op.
REQ-020 LAUNCH: mul_run = 1 for exactly one cycle, drive mul_a = rs1 and mul_b = rs2, then go to WAIT; mul_ready is ignored in LAUNCH.
REQ-021 WAIT: on the first cycle with mul_ready = 1, capture mul_prod into the cache, set cache_valid, record the operands, and go to FIX.
REQ-022 FIX: compute the result from the cached product and register it into resp_data, then go to RESP.
- MUL: lo.
- MULH: hi.
- MULHSU: hi + (rs2[31] ? rs1 : 0).
- MULHU: hi + (rs1[31] ? rs2 : 0) + (rs2[31] ? rs1 : 0).
- All sums are modulo 2^32.
REQ-023 RESP: resp_valid = 1 and resp_data is held stable until resp_ready; then go to IDLE.
REQ-024 Latency: a hit gives resp_valid 2 cycles after accept; a miss gives resp_valid 2 cycles after the capturing mul_ready.
REQ-025 Flush in LAUNCH or WAIT: go to DRAIN and clear cache_valid.
REQ-026 DRAIN: wait for mul_ready, discard the product without touching the cache, then go to IDLE.
REQ-027 Flush in FIX or RESP: go to IDLE, deassert resp_valid next cycle; the cache is retained.
REQ-028 Flush has priority over every other event in the same cycle, including accept and resp_ready.
REQ-029 mul_ready asserted in IDLE, FIX or RESP is ignored.

Reset
REQ-030 Reset forces IDLE.
REQ-031 Reset drives resp_valid = 0, mul_run = 0, resp_data = 0, mul_a = 0, mul_b = 0, and cache_valid = 0.
REQ-032 After reset, req_ready = 1 in the first cycle.
REQ-033 Reset mid-operation abandons the multiplier result; a stale mul_ready after reset is ignored by REQ-029.

Structure
REQ-034 Package mul_pkg holds the op enum (mul_op_t), the state enum (mul_seq_state_t), and the width constants XLEN = 32 and PLEN = 64.
REQ-035 Sub-module mul_fixup: combinational signed-to-unsigned high-word correction per REQ-022.

Verification
REQ-036 MUL rs1 = -10, rs2 = 12, multiplier latency 33 -> one mul_run; resp_data = 0xFFFFFF88 two cycles after mul_ready.
REQ-037 MULH -10 x 12, then MUL -10 x 12 -> the second request issues no mul_run; resp_data = 0xFFFFFFFF, then 0xFFFFFF88 two cycles after accept.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> resp_data = 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> resp_data = 0xFFFFFFFF.
REQ-039 Flush in WAIT -> no resp_valid, req_ready low until mul_ready; the next identical request misses the cache and re-runs the multiplier.
REQ-040 resp_ready held low 5 cycles -> resp_data is stable and req_ready = 0 throughout.
REQ-041 Reset asserted in WAIT with a late mul_ready -> IDLE, no response, cache_valid = 0.
